// File: rtl/common_pkg.sv
// Shared data-bus and access-size types used across the pipeline.
package common;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Load/store unit types and helpers: FSM states, result entry, size decode.
package pipes;
  import common::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    ABORT = 2'd2
  } lsu_state_t;

  // Bit n set means a response FIFO of n entries is supported.
  localparam logic [8:0] RESP_DEPTH_LEGAL = 9'b1_0001_0100;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  tag;
    logic        misalign;
  } lsu_resp_t;

  function automatic logic resp_depth_legal(input int depth);
    logic [3:0] idx;
    idx = depth[3:0];
    return (depth >= 0) && (depth <= 8) && RESP_DEPTH_LEGAL[idx];
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lowmask(input msize_t size);
    unique case (size)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Byte-enable pattern for an access starting at byte lane 0.
  function automatic logic [7:0] size_strobe(input msize_t size);
    unique case (size)
      MSIZE1:  return 8'h01;
      MSIZE2:  return 8'h03;
      MSIZE4:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Truncate right-aligned load data to the access size and extend it.
  function automatic logic [63:0] load_extend(input logic [63:0] d, input msize_t size,
                                              input logic sgn);
    unique case (size)
      MSIZE1:  return {{56{sgn & d[7]}}, d[7:0]};
      MSIZE2:  return {{48{sgn & d[15]}}, d[15:0]};
      MSIZE4:  return {{32{sgn & d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_resp_fifo.sv
// Result queue between the load/store unit and writeback; power-of-two depth.
module resp_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_en;
  logic          pop_en;

  assign empty   = (count == '0);
  assign full    = count[PW];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; clear discards everything queued.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push_en, pop_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage is not reset; an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push_en && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request at a time, runs at most one data-bus
// transaction, and queues results (bypass, misalign trap or bus result).
module mem_access_unit
  import common::*;
  import pipes::*;
#(
  parameter int RESP_DEPTH  = 4,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  msize_t      in_size,
  input  logic        in_read,
  input  logic        in_write,
  input  logic        in_signed,
  input  logic [7:0]  in_tag,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_tag,
  output logic        out_misalign,
  output logic        busy
);

  if (!resp_depth_legal(RESP_DEPTH)) begin : g_bad_depth
    $error("RESP_DEPTH must be 2, 4 or 8");
  end

  lsu_state_t  state_q, state_d;
  logic        ready_en_q;
  dbus_req_t   dreq_q;
  logic [7:0]  ctx_tag_q;
  logic        ctx_signed_q;
  logic        ctx_load_q;

  logic        fifo_full, fifo_empty, fifo_clear, fifo_push, fifo_pop;
  lsu_resp_t   push_entry, head;
  logic        issue, retire, bus_done, misalign, mem_op;
  logic [63:0] load_data;

  assign mem_op    = in_read | in_write;
  assign misalign  = (ALIGN_CHECK != 0) && ((in_addr[2:0] & size_lowmask(in_size)) != 3'b000);
  assign bus_done  = dreq_q.valid & dresp.addr_ok & dresp.data_ok;
  assign load_data = ctx_load_q
                   ? load_extend(dresp.data >> {dreq_q.addr[2:0], 3'b000}, dreq_q.size, ctx_signed_q)
                   : 64'h0;

  // Flush is ignored while an aborted transaction drains.
  assign fifo_clear = flush & (state_q != ABORT);
  assign fifo_pop   = out_valid & out_ready;

  // FSM state register; ready_en_q holds in_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state, handshake and FIFO push decisions.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d    = state_q;
    in_ready   = 1'b0;
    fifo_push  = 1'b0;
    push_entry = '0;
    issue      = 1'b0;
    retire     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ready_en_q & ~fifo_full & ~flush;
        if (in_valid && in_ready) begin
          if (!mem_op || misalign) begin
            fifo_push  = 1'b1;
            push_entry = '{data: in_addr, tag: in_tag, misalign: mem_op & misalign};
          end else begin
            issue   = 1'b1;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (bus_done) begin
          retire     = 1'b1;
          fifo_push  = ~flush;
          push_entry = '{data: load_data, tag: ctx_tag_q, misalign: 1'b0};
          state_d    = IDLE;
        end else if (flush) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (bus_done) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request register: loaded on issue, held until the handshake edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dreq_q       <= '0;
      ctx_tag_q    <= '0;
      ctx_signed_q <= 1'b0;
      ctx_load_q   <= 1'b0;
    end else if (issue) begin
      dreq_q.valid  <= 1'b1;
      dreq_q.addr   <= in_addr;
      dreq_q.size   <= in_size;
      dreq_q.strobe <= in_write ? (size_strobe(in_size) << in_addr[2:0]) : 8'h00;
      dreq_q.data   <= in_wdata << {in_addr[2:0], 3'b000};
      ctx_tag_q     <= in_tag;
      ctx_signed_q  <= in_signed;
      ctx_load_q    <= ~in_write;
    end else if (retire) begin
      dreq_q.valid <= 1'b0;
    end
  end

  resp_fifo #(
    .DEPTH   (RESP_DEPTH),
    .entry_t (lsu_resp_t)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign dreq         = dreq_q;
  assign busy         = (state_q != IDLE);
  assign out_valid    = ~fifo_empty;
  assign out_data     = head.data;
  assign out_tag      = head.tag;
  assign out_misalign = head.misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// results; a monitor pops and compares whenever a result is handed off.
module tb_mem_access_unit;
  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_addr = '0;
  logic [63:0] in_wdata = '0;
  msize_t      in_size = MSIZE1;
  logic        in_read = 1'b0;
  logic        in_write = 1'b0;
  logic        in_signed = 1'b0;
  logic [7:0]  in_tag = '0;
  logic        flush = 1'b0;
  dbus_req_t   dreq;
  dbus_resp_t  dresp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [7:0]  out_tag;
  logic        out_misalign;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  int n_expected = 0;
  lsu_resp_t exp_q[$];

  mem_access_unit #(.RESP_DEPTH(4), .ALIGN_CHECK(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_size      (in_size),
    .in_read      (in_read),
    .in_write     (in_write),
    .in_signed    (in_signed),
    .in_tag       (in_tag),
    .flush        (flush),
    .dreq         (dreq),
    .dresp        (dresp),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .out_misalign (out_misalign),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic lsu_resp_t mk(input logic [63:0] d, input logic [7:0] t, input logic m);
    lsu_resp_t r;
    r.data = d;
    r.tag = t;
    r.misalign = m;
    return r;
  endfunction

  task automatic expect_result(input logic [63:0] d, input logic [7:0] t, input logic m);
    exp_q.push_back(mk(d, t, m));
    n_expected++;
  endtask

  // Present one request and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [63:0] addr, input logic [63:0] wdata, input msize_t size,
                      input logic rd, input logic wr, input logic sgn, input logic [7:0] tag);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_addr = addr;
    in_wdata = wdata;
    in_size = size;
    in_read = rd;
    in_write = wr;
    in_signed = sgn;
    in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Complete the outstanding bus transaction after 'delay' idle cycles.
  task automatic bus_ack(input int delay, input logic [63:0] rdata, input logic [63:0] addr,
                         input logic with_flush);
    repeat (delay) begin
      @(negedge clk);
      check("dreq_held_valid", 64'(dreq.valid), 64'd1);
      check("dreq_held_addr", dreq.addr, addr);
      @(posedge clk);
      #1;
    end
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data = rdata;
    flush = with_flush;
    @(negedge clk);
    check("dreq_valid_at_hs", 64'(dreq.valid), 64'd1);
    @(posedge clk);
    #1;
    dresp = '0;
    flush = 1'b0;
    check("dreq_released", 64'(dreq.valid), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handed-off result must match the oldest expectation.
  initial begin
    lsu_resp_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: got tag 0x%0h data 0x%0h, required no result", out_tag, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", 64'(out_tag), 64'(e.tag));
          check("out_misalign", 64'(out_misalign), 64'(e.misalign));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dreq", 64'(dreq.valid), 64'd0);
    check("rst_dreq_strobe", 64'(dreq.strobe), 64'd0);
    #5 reset = 1'b1;
    #1 check("ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 64'(in_ready), 64'd1);

    // Signed word load at offset 4, handshake on the 3rd cycle
    expect_result(64'hFFFF_FFFF_8000_0000, 8'h01, 1'b0);
    send(64'h1004, 64'h0, MSIZE4, 1'b1, 1'b0, 1'b1, 8'h01);
    check("ld_dreq_valid", 64'(dreq.valid), 64'd1);
    check("ld_dreq_addr", dreq.addr, 64'h1004);
    check("ld_dreq_strobe", 64'(dreq.strobe), 64'h00);
    check("ld_dreq_size", 64'(dreq.size), 64'(MSIZE4));
    check("ld_busy", 64'(busy), 64'd1);
    check("ld_in_ready_bus", 64'(in_ready), 64'd0);
    check("ld_no_early_out", 64'(out_valid), 64'd0);
    bus_ack(2, 64'h8000_0000_0000_0000, 64'h1004, 1'b0);
    check("ld_out_valid_h1", 64'(out_valid), 64'd1);
    check("ld_idle", 64'(busy), 64'd0);
    drain();

    // Byte store at offset 3
    expect_result(64'h0, 8'h02, 1'b0);
    send(64'h2003, 64'hAB, MSIZE1, 1'b0, 1'b1, 1'b0, 8'h02);
    check("st_strobe", 64'(dreq.strobe), 64'h08);
    check("st_data", dreq.data, 64'hAB00_0000);
    check("st_addr", dreq.addr, 64'h2003);
    bus_ack(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2003, 1'b0);
    check("st_out_valid", 64'(out_valid), 64'd1);
    drain();

    // Halfword store in the top lanes, doubleword store
    expect_result(64'h0, 8'h03, 1'b0);
    send(64'h6006, 64'hBEEF, MSIZE2, 1'b0, 1'b1, 1'b0, 8'h03);
    check("st2_strobe", 64'(dreq.strobe), 64'hC0);
    check("st2_data", dreq.data, 64'hBEEF_0000_0000_0000);
    bus_ack(1, 64'h0, 64'h6006, 1'b0);
    expect_result(64'h0, 8'h04, 1'b0);
    send(64'h6000, 64'h1122_3344_5566_7788, MSIZE8, 1'b0, 1'b1, 1'b0, 8'h04);
    check("st8_strobe", 64'(dreq.strobe), 64'hFF);
    check("st8_data", dreq.data, 64'h1122_3344_5566_7788);
    bus_ack(0, 64'h0, 64'h6000, 1'b0);
    drain();

    // Unsigned halfword load and signed byte load
    expect_result(64'h0000_0000_0000_FFEE, 8'h05, 1'b0);
    send(64'h5006, 64'h0, MSIZE2, 1'b1, 1'b0, 1'b0, 8'h05);
    bus_ack(1, 64'hFFEE_0000_0000_0000, 64'h5006, 1'b0);
    expect_result(64'hFFFF_FFFF_FFFF_FF80, 8'h06, 1'b0);
    send(64'h5001, 64'h0, MSIZE1, 1'b1, 1'b0, 1'b1, 8'h06);
    bus_ack(0, 64'h0000_0000_0000_8000, 64'h5001, 1'b0);
    drain();

    // Misaligned load and store: trapped without a bus access
    expect_result(64'h3002, 8'h07, 1'b1);
    send(64'h3002, 64'h0, MSIZE4, 1'b1, 1'b0, 1'b0, 8'h07);
    check("mis_no_dreq", 64'(dreq.valid), 64'd0);
    check("mis_out_valid_t1", 64'(out_valid), 64'd1);
    check("mis_not_busy", 64'(busy), 64'd0);
    drain();
    expect_result(64'h6004, 8'h08, 1'b1);
    send(64'h6004, 64'h55, MSIZE8, 1'b0, 1'b1, 1'b0, 8'h08);
    check("mis_st_no_dreq", 64'(dreq.valid), 64'd0);
    drain();

    // Non-memory bypass
    expect_result(64'hDEAD_BEEF_0000_0010, 8'h09, 1'b0);
    send(64'hDEAD_BEEF_0000_0010, 64'h0, MSIZE8, 1'b0, 1'b0, 1'b0, 8'h09);
    check("byp_out_valid_t1", 64'(out_valid), 64'd1);
    check("byp_no_dreq", 64'(dreq.valid), 64'd0);
    drain();

    // Fill the FIFO with out_ready low: only four accepted
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_read = 1'b0;
      in_write = 1'b0;
      in_addr = 64'h100 + 64'(i);
      in_tag = 8'(8'h10 + i);
      @(negedge clk);
      check($sformatf("fill_ready_%0d", i), 64'(in_ready), 64'(i < 4));
      if (i < 4) expect_result(64'h100 + 64'(i), 8'(8'h10 + i), 1'b0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Flush during BUS: queued bypass dropped, ABORT until handshake, no result
    out_ready = 1'b0;
    send(64'h7777, 64'h0, MSIZE8, 1'b0, 1'b0, 1'b0, 8'h20);
    send(64'h4000, 64'h0, MSIZE8, 1'b1, 1'b0, 1'b0, 8'h21);
    check("fl_pre_out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("fl_abort_busy", 64'(busy), 64'd1);
    check("fl_fifo_empty", 64'(out_valid), 64'd0);
    check("fl_dreq_held", 64'(dreq.valid), 64'd1);
    check("fl_dreq_addr", dreq.addr, 64'h4000);
    out_ready = 1'b1;
    bus_ack(1, 64'h1234, 64'h4000, 1'b0);
    check("fl_no_result", 64'(out_valid), 64'd0);
    check("fl_idle", 64'(busy), 64'd0);

    // Flush in the same cycle as the handshake suppresses the push
    send(64'h4008, 64'h0, MSIZE8, 1'b1, 1'b0, 1'b0, 8'h22);
    bus_ack(0, 64'h5678, 64'h4008, 1'b1);
    check("flhs_no_result", 64'(out_valid), 64'd0);
    check("flhs_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check("flhs_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-BUS with a result queued
    out_ready = 1'b0;
    send(64'h9999, 64'h0, MSIZE8, 1'b0, 1'b0, 1'b0, 8'h30);
    send(64'h5000, 64'h0, MSIZE8, 1'b1, 1'b0, 1'b0, 8'h31);
    check("rb_pre_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rb_dreq_valid", 64'(dreq.valid), 64'd0);
    check("rb_out_valid", 64'(out_valid), 64'd0);
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #3 reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rb_ready_after", 64'(in_ready), 64'd1);
    check("rb_still_empty", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);

    check("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("final_result_count", 64'(n_out), 64'(n_expected));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
